// File: rtl/rggen_apb_register_access_bridge_pkg.sv
// Shared types and helpers for the APB register access bridge.
package rggen_apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bridge_state_e;

  // Byte address bits below this position select a byte inside a word.
  localparam int WORD_LSB       = 2;
  localparam int MAX_BUS_WIDTH  = 1024;
  localparam int MAX_STRB_WIDTH = MAX_BUS_WIDTH / 8;

  // Each strobe bit covers one byte lane of the write mask.
  function automatic logic [MAX_BUS_WIDTH-1:0] expand_strobe(
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_BUS_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/rggen_apb_register_access_bridge_if.sv
// APB completer bus plus the register-side access bus of the bridge.
interface rggen_apb_bridge_if #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int REGISTER_COUNT = 4
);
  import rggen_apb_bridge_pkg::*;

  logic                      i_psel;
  logic                      i_penable;
  logic [ADDRESS_WIDTH-1:0]  i_paddr;
  logic                      i_pwrite;
  logic [BUS_WIDTH-1:0]      i_pwdata;
  logic [BUS_WIDTH/8-1:0]    i_pstrb;
  logic                      o_pready;
  logic [BUS_WIDTH-1:0]      o_prdata;
  logic                      o_pslverr;
  logic                      o_reg_valid;
  logic [REGISTER_COUNT-1:0] o_reg_select;
  logic [BUS_WIDTH-1:0]      o_reg_read_mask;
  logic [BUS_WIDTH-1:0]      o_reg_write_mask;
  logic [BUS_WIDTH-1:0]      o_reg_write_data;
  logic                      i_reg_ready;
  logic [BUS_WIDTH-1:0]      i_reg_read_data;
  logic                      i_reg_status;

  // Host and register array side.
  modport master (
    output i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pstrb,
    input  o_pready, o_prdata, o_pslverr,
    input  o_reg_valid, o_reg_select, o_reg_read_mask, o_reg_write_mask, o_reg_write_data,
    output i_reg_ready, i_reg_read_data, i_reg_status
  );

  // Bridge side.
  modport slave (
    input  i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pstrb,
    output o_pready, o_prdata, o_pslverr,
    output o_reg_valid, o_reg_select, o_reg_read_mask, o_reg_write_mask, o_reg_write_data,
    input  i_reg_ready, i_reg_read_data, i_reg_status
  );

endinterface

// File: rtl/rggen_apb_register_access_bridge_timeout.sv
// Counts BUSY cycles without a register-side response and flags expiry.
module rggen_access_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  if (TIMEOUT_CYCLES > 0) begin : g_on
    logic [CW-1:0] count;

    // Count waiting cycles; cleared whenever the bridge is not waiting.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)         count <= '0;
      else if (i_clear)  count <= '0;
      else if (i_enable) count <= count + CW'(1);
    end

    // This waiting cycle is the one that makes the count reach the limit.
    assign o_expire = i_enable && (count == CW'(TIMEOUT_CYCLES - 1));
  end else begin : g_off
    logic unused_ports;
    assign unused_ports = ^{i_clk, i_rst, i_enable, i_clear};
    assign o_expire     = 1'b0;
  end

endmodule

// File: rtl/rggen_apb_register_access_bridge.sv
// APB4 completer turning each transfer into one register access.
module rggen_apb_register_access_bridge
  import rggen_apb_bridge_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 8,
  parameter int BUS_WIDTH         = 32,
  parameter int REGISTER_COUNT    = 4,
  parameter int TIMEOUT_CYCLES    = 16,
  parameter int ERROR_ON_UNMAPPED = 1
) (
  input logic               i_clk,
  input logic               i_rst,
  rggen_apb_bridge_if.slave bus
);

  localparam int IDX_W  = ADDRESS_WIDTH - WORD_LSB;
  localparam int STRB_W = BUS_WIDTH / 8;
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;
  localparam logic [IDX_W:0] REG_COUNT_V = (IDX_W + 1)'(REGISTER_COUNT);

  logic [1:0]                state;
  logic                      is_write;
  logic [IDX_W-1:0]          idx;
  logic                      mapped;
  logic                      setup;
  logic                      access;
  logic [REGISTER_COUNT-1:0] sel_dec;
  logic [MAX_STRB_WIDTH-1:0] strb_ext;
  logic [BUS_WIDTH-1:0]      strb_mask;
  logic                      tmo_en;
  logic                      tmo_clr;
  logic                      tmo_exp;
  logic                      unused_addr_lsb;

  assign idx             = bus.i_paddr[ADDRESS_WIDTH-1:WORD_LSB];
  assign unused_addr_lsb = ^bus.i_paddr[WORD_LSB-1:0];
  assign mapped          = ({1'b0, idx} < REG_COUNT_V);
  assign setup           = bus.i_psel && !bus.i_penable;
  assign access          = bus.i_psel && bus.i_penable;

  // One-hot register select from the word index.
  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < REGISTER_COUNT; i++) begin
      sel_dec[i] = (idx == IDX_W'(i));
    end
  end

  // Byte strobes widened to a per-bit write mask.
  always_comb begin
    strb_ext             = '0;
    strb_ext[STRB_W-1:0] = bus.i_pstrb;
    strb_mask            = BUS_WIDTH'(expand_strobe(strb_ext));
  end

  assign tmo_en  = (state == ST_BUSY) && !bus.i_reg_ready;
  assign tmo_clr = (state != ST_BUSY);

  rggen_access_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (tmo_en),
    .i_clear  (tmo_clr),
    .o_expire (tmo_exp)
  );

  // Transfer FSM; all bus and register-side outputs are registered here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                <= ST_IDLE;
      is_write             <= 1'b0;
      bus.o_pready         <= 1'b0;
      bus.o_prdata         <= '0;
      bus.o_pslverr        <= 1'b0;
      bus.o_reg_valid      <= 1'b0;
      bus.o_reg_select     <= '0;
      bus.o_reg_read_mask  <= '0;
      bus.o_reg_write_mask <= '0;
      bus.o_reg_write_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            is_write <= bus.i_pwrite;
            if (mapped) begin
              state                <= ST_BUSY;
              bus.o_reg_valid      <= 1'b1;
              bus.o_reg_select     <= sel_dec;
              bus.o_reg_read_mask  <= bus.i_pwrite ? '0 : '1;
              bus.o_reg_write_mask <= bus.i_pwrite ? strb_mask : '0;
              bus.o_reg_write_data <= bus.i_pwrite ? bus.i_pwdata : '0;
            end else begin
              // Unmapped: answer directly without touching the register array.
              state         <= ST_DONE;
              bus.o_pready  <= 1'b1;
              bus.o_prdata  <= '0;
              bus.o_pslverr <= (ERROR_ON_UNMAPPED != 0);
            end
          end
        end
        ST_BUSY: begin
          // Ready is checked first so a response in the expiry cycle wins.
          if (bus.i_reg_ready || tmo_exp) begin
            state                <= ST_DONE;
            bus.o_reg_valid      <= 1'b0;
            bus.o_reg_select     <= '0;
            bus.o_reg_read_mask  <= '0;
            bus.o_reg_write_mask <= '0;
            bus.o_reg_write_data <= '0;
            bus.o_pready         <= 1'b1;
            if (bus.i_reg_ready) begin
              bus.o_prdata  <= is_write ? '0 : bus.i_reg_read_data;
              bus.o_pslverr <= bus.i_reg_status;
            end else begin
              bus.o_prdata  <= '0;
              bus.o_pslverr <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (access) begin
            state         <= ST_IDLE;
            bus.o_pready  <= 1'b0;
            bus.o_prdata  <= '0;
            bus.o_pslverr <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_apb_register_access_bridge.sv
// Randomized and directed bench for the APB register access bridge.
module tb_rggen_apb_register_access_bridge;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b1;

  always #5 clk = ~clk;

  rggen_apb_bridge_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTER_COUNT(4)) a ();
  rggen_apb_bridge_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTER_COUNT(4)) b ();

  rggen_apb_register_access_bridge #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTER_COUNT(4),
    .TIMEOUT_CYCLES(TMO), .ERROR_ON_UNMAPPED(1)
  ) dut (.i_clk(clk), .i_rst(rst), .bus(a));

  rggen_apb_register_access_bridge #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTER_COUNT(4),
    .TIMEOUT_CYCLES(0), .ERROR_ON_UNMAPPED(0)
  ) dut_b (.i_clk(clk), .i_rst(rst), .bus(b));

  // Expected outputs of the main DUT for the current cycle.
  logic        exp_valid, exp_pready, exp_err;
  logic [3:0]  exp_sel;
  logic [31:0] exp_rmask, exp_wmask, exp_wdata, exp_prdata;

  // Observations gathered during one transfer for literal checks.
  int          cyc, obs_vcnt, obs_pat;
  logic [3:0]  obs_sel;
  logic [31:0] obs_rmask, obs_wmask, obs_wdata, obs_prdata;
  logic        obs_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_exp();
    exp_valid = 0; exp_pready = 0; exp_err = 0; exp_sel = 0;
    exp_rmask = 0; exp_wmask = 0; exp_wdata = 0; exp_prdata = 0;
  endtask

  // Single compare process against the model expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",   32'(a.o_reg_valid),  32'(exp_valid));
      chk("select",  32'(a.o_reg_select), 32'(exp_sel));
      chk("rmask",   a.o_reg_read_mask,   exp_rmask);
      chk("wmask",   a.o_reg_write_mask,  exp_wmask);
      chk("wdata",   a.o_reg_write_data,  exp_wdata);
      chk("pready",  32'(a.o_pready),     32'(exp_pready));
      chk("prdata",  a.o_prdata,          exp_prdata);
      chk("pslverr", 32'(a.o_pslverr),    32'(exp_err));
    end
  end

  task automatic tick();
    @(negedge clk);
    if (a.o_reg_valid) begin
      obs_vcnt++;
      obs_sel = a.o_reg_select; obs_rmask = a.o_reg_read_mask;
      obs_wmask = a.o_reg_write_mask; obs_wdata = a.o_reg_write_data;
    end
    if (a.o_pready && obs_pat < 0) begin
      obs_pat = cyc; obs_prdata = a.o_prdata; obs_err = a.o_pslverr;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // mode: 0 = well-formed APB, 1 = psel dropped during BUSY, 2 = stray setup during BUSY
  task automatic xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] strb, input int rlat, input logic [31:0] rd,
                      input logic st, input int mode);
    int idx, nbusy;
    bit mapped, okr;
    logic [31:0] wm;
    idx    = int'(addr) / 4;
    mapped = (idx < 4);
    okr    = mapped && rlat >= 1 && rlat <= TMO;
    nbusy  = !mapped ? 0 : (okr ? rlat : TMO);
    wm = 0;
    for (int i = 0; i < 4; i++) if (strb[i]) wm[8*i +: 8] = 8'hFF;
    cyc = 0; obs_vcnt = 0; obs_pat = -1;
    obs_sel = 0; obs_rmask = 0; obs_wmask = 0; obs_wdata = 0; obs_prdata = 0; obs_err = 0;

    a.i_psel = 1; a.i_penable = 0; a.i_paddr = addr; a.i_pwrite = wr;
    a.i_pwdata = wd; a.i_pstrb = strb;
    clear_exp();
    tick();
    for (int k = 1; k <= nbusy; k++) begin
      a.i_psel    = (mode != 1);
      a.i_penable = (mode == 0);
      // Bus inputs wander after setup; the access must keep the latched values.
      a.i_paddr = 8'($urandom); a.i_pwdata = $urandom; a.i_pstrb = 4'($urandom);
      a.i_pwrite = 1'($urandom);
      a.i_reg_ready     = (k == rlat);
      a.i_reg_read_data = (k == rlat) ? rd : $urandom;
      a.i_reg_status    = (k == rlat) ? st : 1'($urandom);
      exp_valid = 1; exp_sel = 4'(1 << idx);
      exp_rmask = wr ? 32'h0 : 32'hFFFF_FFFF;
      exp_wmask = wr ? wm : 32'h0;
      exp_wdata = wr ? wd : 32'h0;
      tick();
    end
    a.i_reg_ready = 0;
    clear_exp();
    exp_pready = 1;
    exp_err    = !mapped ? 1'b1 : (okr ? st : 1'b1);
    exp_prdata = (okr && !wr) ? rd : 32'h0;
    if (mode != 0) begin
      a.i_psel = 0; a.i_penable = 0;
      tick();
    end
    a.i_psel = 1; a.i_penable = 1;
    tick();
    a.i_psel = 0; a.i_penable = 0;
    clear_exp();
  endtask

  initial begin
    a.i_psel = 0; a.i_penable = 0; a.i_paddr = 0; a.i_pwrite = 0; a.i_pwdata = 0;
    a.i_pstrb = 0; a.i_reg_ready = 0; a.i_reg_read_data = 0; a.i_reg_status = 0;
    b.i_psel = 0; b.i_penable = 0; b.i_paddr = 0; b.i_pwrite = 0; b.i_pwdata = 0;
    b.i_pstrb = 0; b.i_reg_ready = 0; b.i_reg_read_data = 0; b.i_reg_status = 0;
    clear_exp();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_pready", 32'(a.o_pready), 0);
    chk("reset_valid_b", 32'(b.o_reg_valid), 0);

    // Write to index 1, ready in first BUSY cycle.
    xfer(8'h04, 1, 32'hA5A5_0F0F, 4'b0011, 1, 0, 0, 0);
    chk("w1_select", 32'(obs_sel), 32'h2);
    chk("w1_wmask", obs_wmask, 32'h0000_FFFF);
    chk("w1_rmask", obs_rmask, 32'h0);
    chk("w1_wdata", obs_wdata, 32'hA5A5_0F0F);
    chk("w1_vcnt", obs_vcnt, 1);
    chk("w1_pready_at", obs_pat, 2);
    chk("w1_err", 32'(obs_err), 0);

    // Read of index 2, ready on third BUSY cycle (issued back to back).
    xfer(8'h08, 0, 0, 4'hF, 3, 32'h1234_5678, 0, 0);
    chk("r2_rmask", obs_rmask, 32'hFFFF_FFFF);
    chk("r2_vcnt", obs_vcnt, 3);
    chk("r2_pready_at", obs_pat, 4);
    chk("r2_prdata", obs_prdata, 32'h1234_5678);

    // Unmapped read.
    xfer(8'h10, 0, 0, 4'hF, 1, 32'h5555_5555, 0, 0);
    chk("um_vcnt", obs_vcnt, 0);
    chk("um_pready_at", obs_pat, 1);
    chk("um_err", 32'(obs_err), 1);
    chk("um_prdata", obs_prdata, 0);

    // Timeout with no ready, then ready exactly in the expiry cycle.
    xfer(8'h0C, 0, 0, 4'hF, 0, 0, 0, 0);
    chk("to_vcnt", obs_vcnt, 4);
    chk("to_pready_at", obs_pat, 5);
    chk("to_err", 32'(obs_err), 1);
    chk("to_prdata", obs_prdata, 0);
    xfer(8'h00, 0, 0, 4'hF, 4, 32'hDEAD_BEEF, 0, 0);
    chk("tr_vcnt", obs_vcnt, 4);
    chk("tr_err", 32'(obs_err), 0);
    chk("tr_prdata", obs_prdata, 32'hDEAD_BEEF);

    // Register-side error on a write; zero-strobe write; low address bits ignored.
    xfer(8'h04, 1, 32'h1111_2222, 4'hF, 2, 32'h9999_9999, 1, 0);
    chk("st_err", 32'(obs_err), 1);
    chk("st_prdata", obs_prdata, 0);
    xfer(8'h08, 1, 32'hFFFF_FFFF, 4'h0, 1, 0, 0, 0);
    chk("z_vcnt", obs_vcnt, 1);
    chk("z_wmask", obs_wmask, 0);
    xfer(8'h0F, 0, 0, 4'h0, 1, 32'h0BAD_F00D, 0, 2);
    chk("lsb_select", 32'(obs_sel), 32'h8);
    chk("lsb_prdata", obs_prdata, 32'h0BAD_F00D);

    // Reset pulse in the middle of BUSY.
    chk_en = 0;
    a.i_psel = 1; a.i_penable = 0; a.i_paddr = 8'h0C; a.i_pwrite = 0;
    @(posedge clk); #1;
    a.i_penable = 1;
    #2;
    chk("mid_valid_before", 32'(a.o_reg_valid), 1);
    rst = 1; #1;
    chk("rst_valid", 32'(a.o_reg_valid), 0);
    chk("rst_select", 32'(a.o_reg_select), 0);
    chk("rst_rmask", a.o_reg_read_mask, 0);
    chk("rst_pready", 32'(a.o_pready), 0);
    rst = 0;
    a.i_psel = 0; a.i_penable = 0;
    @(posedge clk); #1;
    // Reset while pready is held in DONE.
    a.i_psel = 1; a.i_paddr = 8'h20;
    @(posedge clk); #1;
    a.i_penable = 1;
    #2;
    chk("done_pready_before", 32'(a.o_pready), 1);
    rst = 1; #1;
    chk("rst_done_pready", 32'(a.o_pready), 0);
    chk("rst_done_err", 32'(a.o_pslverr), 0);
    rst = 0;
    a.i_psel = 0; a.i_penable = 0;
    @(posedge clk); #1;
    chk_en = 1;
    xfer(8'h0C, 0, 0, 4'hF, 2, 32'h7777_0001, 0, 0);
    chk("post_rst_prdata", obs_prdata, 32'h7777_0001);
    chk("post_rst_pready_at", obs_pat, 3);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] ad;
      ad = 8'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3));
      xfer(ad, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 6),
           $urandom, 1'($urandom), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Second instance: unmapped is OKAY, and no timeout exists.
    b.i_psel = 1; b.i_paddr = 8'h10; b.i_pwrite = 0;
    @(posedge clk); #1;
    b.i_penable = 1;
    @(negedge clk);
    chk("b_um_pready", 32'(b.o_pready), 1);
    chk("b_um_err", 32'(b.o_pslverr), 0);
    chk("b_um_prdata", b.o_prdata, 0);
    chk("b_um_valid", 32'(b.o_reg_valid), 0);
    @(posedge clk); #1;
    b.i_psel = 0; b.i_penable = 0;
    @(posedge clk); #1;
    b.i_psel = 1; b.i_paddr = 8'h04;
    @(posedge clk); #1;
    b.i_penable = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("b_long_valid", 32'(b.o_reg_valid), 1);
    b.i_reg_ready = 1; b.i_reg_read_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    b.i_reg_ready = 0;
    @(negedge clk);
    chk("b_long_pready", 32'(b.o_pready), 1);
    chk("b_long_err", 32'(b.o_pslverr), 0);
    chk("b_long_prdata", b.o_prdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    b.i_psel = 0; b.i_penable = 0;
    @(negedge clk);
    chk("b_idle_pready", 32'(b.o_pready), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
